// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the stored-program sequencer: instruction fields,
// opcodes and the controller state encoding.
package cpu_seq_pkg;

    localparam int WORD_W   = 9;
    localparam int OPC_HI   = 8;
    localparam int OPC_LO   = 7;
    localparam int OPND_W   = 7;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LDI  = 2'b10,
        OP_HALT = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } state_e;

    function automatic opcode_e get_opcode(input logic [WORD_W-1:0] word);
        return opcode_e'(word[OPC_HI:OPC_LO]);
    endfunction

    function automatic logic [OPND_W-1:0] get_operand(input logic [WORD_W-1:0] word);
        return word[OPND_W-1:0];
    endfunction

endpackage

// File: rtl/cpu_seq_progmem.sv
// Instruction store: DEPTH x 9 register array with one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset;
// the controller's word count decides which slots are valid.
module cpu_seq_progmem
    import cpu_seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_waddr,
    input  logic [WORD_W-1:0]   i_wdata,
    input  logic [ADDR_W-1:0]   i_raddr,
    output logic [WORD_W-1:0]   o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Store an accepted load word.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Program sequencer for the 9-bit accumulator datapath. Words are loaded into
// a small store, then executed one per two cycles (FETCH, EXEC), driving the
// datapath strobe and mux selects from registered outputs.
//
// state | meaning
// IDLE  | accepting loads; start launches a run, clear empties the store
// FETCH | read word at pc, prepare registered datapath outputs
// EXEC  | datapath outputs valid; advance pc or stop
// HALT  | program finished; start re-runs, clear empties the store
module cpu_seq_ctrl
    import cpu_seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                load_valid,
    input  logic [8:0]          load_data,
    output logic                load_ready,
    input  logic                clear,
    input  logic                start,
    output logic                busy,
    output logic                halted,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W:0]     count,
    output logic [8:0]          dp_data,
    output logic                dp_write_en,
    output logic                dp_is_add,
    output logic                dp_is_imm,
    output logic [7:0]          dp_imm
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W:0]     r_count;
    opcode_e             r_ir_op;
    logic [8:0]          r_dp_data;
    logic                r_dp_write_en;
    logic                r_dp_is_add;
    logic                r_dp_is_imm;
    logic [7:0]          r_dp_imm;

    logic                w_ctl_state;
    logic                w_load_ok;
    logic                w_load_acc;
    logic                w_clear;
    logic                w_start_go;
    logic                w_mem_we;
    logic                w_last;
    logic [WORD_W-1:0]   w_rdata;
    opcode_e             w_op;
    logic [OPND_W-1:0]   w_operand;

    cpu_seq_progmem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_progmem (
        .CLK     (CLK),
        .i_we    (w_mem_we),
        .i_waddr (r_count[ADDR_W-1:0]),
        .i_wdata (load_data),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

    // Handshake and command qualification. clear beats both start and a
    // same-cycle load; a word accepted alongside start is part of the run.
    always_comb begin
        w_ctl_state = (r_state == IDLE) || (r_state == HALT);
        w_load_ok   = (r_state == IDLE) && (r_count < L_DEPTH);
        w_load_acc  = load_valid && w_load_ok;
        w_clear     = clear && w_ctl_state;
        w_mem_we    = w_load_acc && !w_clear;
        w_start_go  = start && w_ctl_state && !w_clear &&
                      ((r_count != '0) || w_load_acc);
        w_last      = ({1'b0, r_pc} == (r_count - (ADDR_W+1)'(1)));
        w_op        = get_opcode(w_rdata);
        w_operand   = get_operand(w_rdata);
    end

    // Sequencer FSM with registered datapath outputs, valid only in EXEC.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_count       <= '0;
            r_ir_op       <= OP_ADD;
            r_dp_data     <= '0;
            r_dp_write_en <= 1'b0;
            r_dp_is_add   <= 1'b0;
            r_dp_is_imm   <= 1'b0;
            r_dp_imm      <= '0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (w_clear) begin
                        r_count <= '0;
                        r_pc    <= '0;
                        r_state <= IDLE;
                    end else begin
                        if (w_load_acc) begin
                            r_count <= r_count + (ADDR_W+1)'(1);
                        end
                        if (w_start_go) begin
                            r_pc    <= '0;
                            r_state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    r_ir_op       <= w_op;
                    r_dp_write_en <= (w_op != OP_HALT);
                    r_dp_is_add   <= (w_op == OP_ADD);
                    r_dp_is_imm   <= (w_op == OP_LDI);
                    r_dp_data     <= ((w_op == OP_ADD) || (w_op == OP_SUB)) ?
                                     {2'b00, w_operand} : 9'd0;
                    r_dp_imm      <= (w_op == OP_LDI) ? {1'b0, w_operand} : 8'd0;
                    r_state       <= EXEC;
                end
                EXEC: begin
                    r_dp_data     <= '0;
                    r_dp_write_en <= 1'b0;
                    r_dp_is_add   <= 1'b0;
                    r_dp_is_imm   <= 1'b0;
                    r_dp_imm      <= '0;
                    if ((r_ir_op == OP_HALT) || w_last) begin
                        r_state <= HALT;
                    end else begin
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign load_ready  = w_load_ok;
    assign busy        = (r_state == FETCH) || (r_state == EXEC);
    assign halted      = (r_state == HALT);
    assign pc          = r_pc;
    assign count       = r_count;
    assign dp_data     = r_dp_data;
    assign dp_write_en = r_dp_write_en;
    assign dp_is_add   = r_dp_is_add;
    assign dp_is_imm   = r_dp_is_imm;
    assign dp_imm      = r_dp_imm;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: the driver predicts every datapath
// strobe (cycle and fields) from a queue model of the program store; a
// monitor pops and compares whenever the DUT strobes.
module tb_cpu_seq_ctrl;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               load_valid = 1'b0;
    logic [8:0]         load_data = '0;
    logic               load_ready;
    logic               clear = 1'b0;
    logic               start = 1'b0;
    logic               busy;
    logic               halted;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W:0]    count;
    logic [8:0]         dp_data;
    logic               dp_write_en;
    logic               dp_is_add;
    logic               dp_is_imm;
    logic [7:0]         dp_imm;

    cpu_seq_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .clear       (clear),
        .start       (start),
        .busy        (busy),
        .halted      (halted),
        .pc          (pc),
        .count       (count),
        .dp_data     (dp_data),
        .dp_write_en (dp_write_en),
        .dp_is_add   (dp_is_add),
        .dp_is_imm   (dp_is_imm),
        .dp_imm      (dp_imm)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [1:0] op;
        logic [8:0] data;
        logic [7:0] imm;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [8:0] m_store[$];
    bit         m_idle = 1'b1;
    int         m_pc = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (dp_write_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_cycle", cyc, mon_e.cyc);
                    check("dp_is_imm", dp_is_imm, (mon_e.op == 2'd2) ? 1 : 0);
                    if (mon_e.op == 2'd2) begin
                        check("dp_imm", dp_imm, mon_e.imm);
                    end else begin
                        check("dp_data", dp_data, mon_e.data);
                        check("dp_is_add", dp_is_add, (mon_e.op == 2'd0) ? 1 : 0);
                    end
                end
            end else begin
                check("dp_zero_no_strobe", {dp_data, dp_is_add, dp_is_imm, dp_imm}, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    check("missed_strobe", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Program semantics: walk the store from slot 0, stopping at HALT or
    // the last stored word; instruction i strobes at c+2+2i.
    task automatic model_run(input int c);
        logic [8:0] w;
        exp_t e;
        for (int i = 0; i < m_store.size(); i++) begin
            w = m_store[i];
            if (w[8:7] == 2'd3) begin
                m_pc = i;
                break;
            end
            e.cyc  = c + 2 + 2 * i;
            e.op   = w[8:7];
            e.data = {2'b00, w[6:0]};
            e.imm  = {1'b0, w[6:0]};
            exp_q.push_back(e);
            if (i == m_store.size() - 1) begin
                m_pc = i;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [8:0] w);
        bit ok;
        load_valid = 1'b1;
        load_data  = w;
        ok = m_idle && (m_store.size() < DEPTH);
        check("load_ready", load_ready, ok);
        if (ok) m_store.push_back(w);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!halted && n < 200) begin
            if (busy) check("load_ready_busy", load_ready, 0);
            load_valid = $urandom_range(0, 1);
            load_data  = 9'($urandom);
            tick();
            n++;
        end
        load_valid = 1'b0;
        check("halt_reached", halted, 1);
        check("pc_at_halt", pc, m_pc);
        check("busy_in_halt", busy, 0);
        check("count_after_run", count, m_store.size());
        check("all_strobes_seen", exp_q.size(), 0);
        m_idle = 1'b0;
    endtask

    task automatic do_start(input bit with_load, input logic [8:0] w, input bit with_clear);
        bit run = 1'b0;
        bit was_halt = !m_idle;
        int c = cyc;
        start = 1'b1;
        clear = with_clear;
        if (with_load) begin
            load_valid = 1'b1;
            load_data  = w;
        end
        if (with_clear) begin
            m_store.delete();
            m_idle = 1'b1;
        end else begin
            if (with_load && m_idle && m_store.size() < DEPTH) m_store.push_back(w);
            if (m_store.size() > 0) begin
                run = 1'b1;
                model_run(c);
            end
        end
        tick();
        start = 1'b0;
        clear = 1'b0;
        load_valid = 1'b0;
        if (run) begin
            check("busy_after_start", busy, 1);
            wait_halt();
        end else begin
            check("busy_no_run", busy, 0);
            check("halted_no_run", halted, (was_halt && !with_clear) ? 1 : 0);
            check("count_no_run", count, m_store.size());
        end
    endtask

    initial begin
        logic [8:0] w;
        int n;
        int c;
        int k;

        tick();
        tick();
        check("rst_pc", pc, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_strobe", dp_write_en, 0);
        RESET = 1'b0;
        tick();
        check("rst_load_ready", load_ready, 1);

        // ADD 5, SUB 3, HALT
        do_load(9'h005);
        do_load(9'h083);
        do_load(9'h180);
        check("count3", count, 3);
        do_start(1'b0, '0, 1'b0);
        check("halt_pc2", pc, 2);

        // clear + start together in HALT
        do_start(1'b0, '0, 1'b1);
        check("clear_count", count, 0);
        check("clear_ready", load_ready, 1);

        // LDI 0x2A alone, run twice
        do_load(9'h12A);
        do_start(1'b0, '0, 1'b0);
        check("ldi_pc0", pc, 0);
        do_start(1'b0, '0, 1'b0);
        do_start(1'b0, '0, 1'b1);

        // overfill with load_valid held
        for (int i = 1; i <= 10; i++) do_load(9'(i));
        check("full_count", count, DEPTH);
        check("full_ready", load_ready, 0);
        do_start(1'b0, '0, 1'b0);
        do_start(1'b0, '0, 1'b1);

        // start on empty store, then start with same-cycle load
        do_start(1'b0, '0, 1'b0);
        tick();
        check("empty_busy", busy, 0);
        do_start(1'b1, 9'h007, 1'b0);
        do_start(1'b0, '0, 1'b1);

        // reset during EXEC of the second of three ADDs
        do_load(9'h001);
        do_load(9'h002);
        do_load(9'h003);
        c = cyc;
        start = 1'b1;
        model_run(c);
        tick();
        start = 1'b0;
        m_idle = 1'b0;
        while (cyc < c + 4) tick();
        RESET = 1'b1;
        #1;
        check("rstx_strobe", dp_write_en, 0);
        check("rstx_pc", pc, 0);
        check("rstx_count", count, 0);
        check("rstx_busy", busy, 0);
        check("rstx_halted", halted, 0);
        exp_q.delete();
        m_store.delete();
        m_idle = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        do_start(1'b0, '0, 1'b0);
        do_load(9'h004);
        do_start(1'b0, '0, 1'b0);

        // randomized programs
        for (int r = 0; r < 20; r++) begin
            do_start(1'b0, '0, 1'b1);
            n = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < n; i++) begin
                k = ($urandom_range(0, 5) == 0) ? 3 : $urandom_range(0, 2);
                w = {2'(k), 7'($urandom)};
                if (i == n - 1 && $urandom_range(0, 1) == 1) begin
                    do_start(1'b1, w, 1'b0);
                end else begin
                    do_load(w);
                    if ($urandom_range(0, 3) == 0) tick();
                    if (i == n - 1) do_start(1'b0, '0, 1'b0);
                end
            end
        end

        repeat (4) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
